board_search_ctrl: RTL and testbench



---
 rtl/board_pkg.sv | 14 +
 rtl/board_cmp.sv | 20 ++
 rtl/board_search_ctrl.sv | 84 ++++++++
 tb/tb_board_search_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// board_pkg: shared constants, state encoding and result packing for the board search datapath.
package board_pkg;
  localparam int CELL_W = 3;
  localparam int BOARD_W = 6 * CELL_W;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 28;
  localparam int NUM_BOARDS = 60;
  localparam int QUESTION_ADDR = 60;
  localparam int RESULT_ADDR = 4;
  typedef enum logic [2:0] {IDLE, LOADQ, SCAN, WRITE, DONE} state_t;
  function automatic logic [DATA_W-1:0] pack_result(input logic found, input logic [ADDR_W-1:0] idx);
    return {found, {(DATA_W-ADDR_W-1){1'b0}}, idx};
  endfunction
endpackage

// File: rtl/board_cmp.sv
// board_cmp: two-entry compare against the target, port A first, port B masked past the table end.
module board_cmp #(
  parameter int BOARD_W = board_pkg::BOARD_W,
  parameter int ADDR_W = board_pkg::ADDR_W,
  parameter int NUM_BOARDS = board_pkg::NUM_BOARDS
) (
  input  logic [BOARD_W-1:0] a,
  input  logic [BOARD_W-1:0] b,
  input  logic [BOARD_W-1:0] target,
  input  logic [ADDR_W-1:0]  idx,
  output logic               hit,
  output logic               off
);
  localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(NUM_BOARDS);
  logic hit_a, hit_b;
  assign hit_a = a == target;
  assign hit_b = (b == target) && (({1'b0, idx} + (ADDR_W+1)'(1)) < LIM);
  assign hit = hit_a | hit_b;
  assign off = ~hit_a;
endmodule

// File: rtl/board_search_ctrl.sv
// board_search_ctrl: loads the question board, scans the table two entries per cycle,
// writes {found, index} to the result slot and pulses done.
module board_search_ctrl
  import board_pkg::*;
#(
  parameter int ADDR_W = board_pkg::ADDR_W,
  parameter int DATA_W = board_pkg::DATA_W,
  parameter int BOARD_W = board_pkg::BOARD_W,
  parameter int NUM_BOARDS = board_pkg::NUM_BOARDS,
  parameter int QUESTION_ADDR = board_pkg::QUESTION_ADDR,
  parameter int RESULT_ADDR = board_pkg::RESULT_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [ADDR_W-1:0] match_idx,
  output logic [ADDR_W-1:0] src0,
  output logic [ADDR_W-1:0] src1,
  input  logic [DATA_W-1:0] outa,
  input  logic [DATA_W-1:0] outb,
  output logic [ADDR_W-1:0] dst,
  output logic              we,
  output logic [DATA_W-1:0] data
);
  localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(NUM_BOARDS);
  state_t state;
  logic [ADDR_W-1:0] idx;
  logic [BOARD_W-1:0] target;
  logic hit, off, last;
  logic unused;
  assign unused = ^{outa[DATA_W-1:BOARD_W], outb[DATA_W-1:BOARD_W]};
  board_cmp #(.BOARD_W(BOARD_W), .ADDR_W(ADDR_W), .NUM_BOARDS(NUM_BOARDS)) u_cmp (
    .a(outa[BOARD_W-1:0]),
    .b(outb[BOARD_W-1:0]),
    .target(target),
    .idx(idx),
    .hit(hit),
    .off(off)
  );
  assign last = ({1'b0, idx} + (ADDR_W+1)'(2)) >= LIM;
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
    we = state == WRITE;
    src0 = state == LOADQ ? ADDR_W'(QUESTION_ADDR) : state == SCAN ? idx : '0;
    src1 = state == SCAN ? idx + ADDR_W'(1) : '0;
    dst = we ? ADDR_W'(RESULT_ADDR) : '0;
    data = we ? {found, {(DATA_W-ADDR_W-1){1'b0}}, match_idx} : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      target <= '0;
      found <= 1'b0;
      match_idx <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= LOADQ;
          found <= 1'b0;
          match_idx <= '0;
        end
        LOADQ: begin
          target <= outa[BOARD_W-1:0];
          idx <= '0;
          state <= SCAN;
        end
        SCAN: if (hit) begin
          found <= 1'b1;
          match_idx <= idx + ADDR_W'(off);
          state <= WRITE;
        end else if (last) state <= WRITE;
        else idx <= idx + ADDR_W'(2);
        WRITE: state <= DONE;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_board_search_ctrl.sv
// tb_board_search_ctrl: scoreboard bench with a 60-entry and a 5-entry instance, each on its own register file model.
module tb_board_search_ctrl;
  import board_pkg::*;
  typedef struct {logic f; logic [5:0] m; logic [27:0] d; int lat; int s;} exp_t;
  logic clk = 1'b0, rst;
  always #5 clk = ~clk;
  int cyc = 0, n_chk = 0, n_fail = 0, wrs_b = 0, wrs_s = 0;
  always @(posedge clk) cyc <= cyc + 1;
  exp_t qb[$], qs[$];
  exp_t eb, es;
  logic start_b, busy_b, done_b, found_b, we_b;
  logic [5:0] midx_b, src0_b, src1_b, dst_b;
  logic [27:0] outa_b, outb_b, data_b;
  logic [27:0] mem_b [64];
  logic start_s, busy_s, done_s, found_s, we_s;
  logic [5:0] midx_s, src0_s, src1_s, dst_s;
  logic [27:0] outa_s, outb_s, data_s;
  logic [27:0] mem_s [64];
  logic [27:0] marker;
  assign outa_b = mem_b[src0_b];
  assign outb_b = mem_b[src1_b];
  assign outa_s = mem_s[src0_s];
  assign outb_s = mem_s[src1_s];
  always @(posedge clk) if (we_b) mem_b[dst_b] <= data_b;
  always @(posedge clk) if (we_s) mem_s[dst_s] <= data_s;

  board_search_ctrl u_big (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .found(found_b),
    .match_idx(midx_b), .src0(src0_b), .src1(src1_b), .outa(outa_b), .outb(outb_b),
    .dst(dst_b), .we(we_b), .data(data_b)
  );
  board_search_ctrl #(.NUM_BOARDS(5)) u_small (
    .clk(clk), .rst(rst), .start(start_s), .busy(busy_s), .done(done_s), .found(found_s),
    .match_idx(midx_s), .src0(src0_s), .src1(src1_s), .outa(outa_s), .outb(outb_s),
    .dst(dst_s), .we(we_s), .data(data_s)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) if (!rst) begin
    if (we_b) begin
      if (qb.size() == 0) chk("big unexpected write", 32'(we_b), 0);
      else begin
        chk("big wr dst", 32'(dst_b), RESULT_ADDR);
        chk("big wr data", 32'(data_b), 32'(qb[0].d));
        wrs_b++;
      end
    end
    if (done_b) begin
      if (qb.size() == 0) chk("big unexpected done", 32'(done_b), 0);
      else begin
        eb = qb.pop_front();
        chk("big found", 32'(found_b), 32'(eb.f));
        chk("big match_idx", 32'(midx_b), 32'(eb.m));
        chk("big latency", 32'(cyc - eb.s + 1), 32'(eb.lat));
        chk("big write count", 32'(wrs_b), 1);
        wrs_b = 0;
      end
    end
  end

  always @(negedge clk) if (!rst) begin
    if (we_s) begin
      if (qs.size() == 0) chk("small unexpected write", 32'(we_s), 0);
      else begin
        chk("small wr dst", 32'(dst_s), RESULT_ADDR);
        chk("small wr data", 32'(data_s), 32'(qs[0].d));
        wrs_s++;
      end
    end
    if (done_s) begin
      if (qs.size() == 0) chk("small unexpected done", 32'(done_s), 0);
      else begin
        es = qs.pop_front();
        chk("small found", 32'(found_s), 32'(es.f));
        chk("small match_idx", 32'(midx_s), 32'(es.m));
        chk("small latency", 32'(cyc - es.s + 1), 32'(es.lat));
        chk("small write count", 32'(wrs_s), 1);
        wrs_s = 0;
      end
    end
  end

  function automatic exp_t mk(input logic f, input logic [5:0] m, input int k);
    exp_t e;
    e.f = f;
    e.m = m;
    e.d = {f, 21'b0, m};
    e.lat = k + 3;
    e.s = 0;
    return e;
  endfunction

  task automatic run_b(input logic f, input logic [5:0] m, input int k);
    exp_t e;
    e = mk(f, m, k);
    @(negedge clk);
    start_b = 1'b1;
    e.s = cyc + 1;
    qb.push_back(e);
    @(negedge clk);
    start_b = 1'b0;
  endtask

  task automatic run_s(input logic f, input logic [5:0] m, input int k);
    exp_t e;
    e = mk(f, m, k);
    @(negedge clk);
    start_s = 1'b1;
    e.s = cyc + 1;
    qs.push_back(e);
    @(negedge clk);
    start_s = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 100 && (qb.size() + qs.size()) > 0; i++) @(negedge clk);
    chk(nm, 32'(qb.size() + qs.size()), 0);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    start_b = 1'b0;
    start_s = 1'b0;
    for (int i = 0; i < 64; i++) begin
      mem_b[i] = 28'(32'h01053 + i);
      mem_s[i] = 28'(32'h02000 + i);
    end
    mem_b[59] = 28'h0023445;
    mem_b[60] = 28'h0023445;
    mem_s[5] = 28'h00155AA;
    mem_s[60] = 28'h00155AA;
    repeat (3) @(negedge clk);
    chk("rst busy", 32'(busy_b), 0);
    chk("rst done", 32'(done_b), 0);
    chk("rst we", 32'(we_b), 0);
    chk("rst src0", 32'(src0_b), 0);
    chk("rst src1", 32'(src1_b), 0);
    chk("rst dst", 32'(dst_b), 0);
    chk("rst data", 32'(data_b), 0);
    chk("rst found", 32'(found_b), 0);
    chk("rst match_idx", 32'(midx_b), 0);
    chk("rst small busy", 32'(busy_s), 0);
    rst = 1'b0;
    // match in the last entry, seen on port B of pair (58,59)
    run_b(1'b1, 6'd59, 30);
    drain("timeout last entry");
    mem_b[60] = 28'h0001053;
    run_b(1'b1, 6'd0, 1);
    drain("timeout first entry");
    mem_b[60] = 28'h003FFFF;
    run_b(1'b0, 6'd0, 30);
    drain("timeout miss");
    mem_b[3] = 28'hFFC1056;
    mem_b[60] = 28'h0001056;
    run_b(1'b1, 6'd3, 2);
    drain("timeout upper bits");
    // only the entry just past a 5-entry table matches; it must be masked
    run_s(1'b0, 6'd0, 3);
    drain("timeout odd tail");
    // start pulses in SCAN and in DONE must not disturb or restart the search
    mem_b[60] = 28'h0023445;
    run_b(1'b1, 6'd59, 30);
    repeat (5) @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    repeat (26) @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    @(negedge clk);
    chk("start ignored in DONE", 32'(busy_b), 0);
    drain("timeout busy start");
    // reset during the 10th SCAN cycle aborts without a write
    marker = 28'h0ABCDEF;
    mem_b[4] = marker;
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    repeat (10) @(negedge clk);
    chk("busy before abort", 32'(busy_b), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort busy", 32'(busy_b), 0);
    chk("abort we", 32'(we_b), 0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort no result write", 32'(mem_b[4]), 32'(marker));
    chk("abort stays idle", 32'(busy_b), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
